// File: rtl/peak_scanner_pkg.sv
// peak_scanner_pkg -- shared types and helpers for the peak scanner.
//   state_t    : scanner FSM states
//   sample_gt  : strict greater-than on zero-extended samples, optionally
//                treating them as two's-complement of the given width
package peak_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    localparam int CMP_W = 32;

    // Signed compare is done by flipping the sample sign bit, which maps
    // two's-complement ordering onto unsigned ordering.
    function automatic logic sample_gt(input logic [CMP_W-1:0] a,
                                       input logic [CMP_W-1:0] b,
                                       input bit               is_signed,
                                       input int               width);
        logic [CMP_W-1:0] bias;
        bias = is_signed ? (32'd1 << (width - 1)) : '0;
        return (a ^ bias) > (b ^ bias);
    endfunction

endpackage

// File: rtl/peak_scanner_if.sv
// peak_scanner_if -- RAM read port between the scanner and sample memory.
//   data_addr : read address
//   data_rd   : read strobe
//   data      : read data, valid a fixed latency after its strobe
//   master    : scanner side; slave : memory side
interface peak_scanner_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  data_rd;
    logic [DATA_WIDTH-1:0] data;

    modport master (output data_addr, output data_rd, input data);
    modport slave  (input data_addr, input data_rd, output data);
endinterface

// File: rtl/peak_tag_pipe.sv
// peak_tag_pipe -- DEPTH-stage valid/index delay line that pairs each
// returned RAM sample with the address that produced it.
//   clk, rst_n           : clock, async active-low reset
//   flush                : synchronous clear of all valid bits
//   in_valid, in_index   : strobe and address entering the line
//   out_valid, out_index : tag aligned with the returned sample
module peak_tag_pipe #(
    parameter int DEPTH      = 1,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_index,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_index
);
    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] index_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) index_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            index_q[0] <= in_index;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                index_q[i] <= index_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_index = index_q[DEPTH-1];
endmodule

// File: rtl/peak_scanner.sv
// peak_scanner -- scans len_m1+1 RAM words from base_addr and reports the
// largest sample and its address.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : begin a scan (IDLE only) / cancel a scan
//   base_addr, len_m1   : scan window, captured on start
//   bus (master)        : RAM read port
//   max, max_index      : committed peak and its address
//   max2, max2_index, max2_valid : runner-up, only with PEAK_SCANNER_SECOND_EN
//   busy, done          : scan in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one read strobe per cycle
// DRAIN | waiting for outstanding reads to return
// DONE  | results committed, done pulse
module peak_scanner
    import peak_scanner_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len_m1,
    peak_scanner_if.master        bus,
    output logic [DATA_WIDTH-1:0] max,
    output logic [ADDR_WIDTH-1:0] max_index,
`ifdef PEAK_SCANNER_SECOND_EN
    output logic [DATA_WIDTH-1:0] max2,
    output logic [ADDR_WIDTH-1:0] max2_index,
    output logic                  max2_valid,
`endif
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q, cnt_q;
    logic [2:0]            dcnt_q;
    logic                  first_q;
    logic                  start_ok, stop, commit;
    logic                  tag_valid;
    logic [ADDR_WIDTH-1:0] tag_index;
    logic [DATA_WIDTH-1:0] sh_max, sh_max_nx;
    logic [ADDR_WIDTH-1:0] sh_idx, sh_idx_nx;
`ifdef PEAK_SCANNER_SECOND_EN
    logic [DATA_WIDTH-1:0] sh2_max, sh2_max_nx;
    logic [ADDR_WIDTH-1:0] sh2_idx, sh2_idx_nx;
    logic                  sh2_vld, sh2_vld_nx;
`endif

    assign start_ok = (state == IDLE) && start && !abort;
    assign stop     = abort && ((state == SCAN) || (state == DRAIN));
    assign commit   = (state == DRAIN) && (state_nx == DONE);

    assign bus.data_rd   = (state == SCAN);
    assign bus.data_addr = addr_q;
    assign busy          = (state == SCAN) || (state == DRAIN);
    assign done          = (state == DONE);

    peak_tag_pipe #(.DEPTH(RD_LATENCY), .ADDR_WIDTH(ADDR_WIDTH)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (stop),
        .in_valid  (bus.data_rd),
        .in_index  (addr_q),
        .out_valid (tag_valid),
        .out_index (tag_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = SCAN;
            SCAN:    if (abort) state_nx = IDLE;
                     else if (cnt_q == '0) state_nx = DRAIN;
            DRAIN:   if (abort) state_nx = IDLE;
                     else if (dcnt_q == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Running peak over returned samples; the first sample of a scan seeds it.
    always_comb begin
        sh_max_nx = sh_max;
        sh_idx_nx = sh_idx;
`ifdef PEAK_SCANNER_SECOND_EN
        sh2_max_nx = sh2_max;
        sh2_idx_nx = sh2_idx;
        sh2_vld_nx = sh2_vld;
`endif
        if (tag_valid) begin
            if (first_q) begin
                sh_max_nx = bus.data;
                sh_idx_nx = tag_index;
`ifdef PEAK_SCANNER_SECOND_EN
                sh2_vld_nx = 1'b0;
`endif
            end else if (sample_gt(32'(bus.data), 32'(sh_max), SIGNED, DATA_WIDTH)) begin
`ifdef PEAK_SCANNER_SECOND_EN
                sh2_max_nx = sh_max;
                sh2_idx_nx = sh_idx;
                sh2_vld_nx = 1'b1;
`endif
                sh_max_nx = bus.data;
                sh_idx_nx = tag_index;
            end
`ifdef PEAK_SCANNER_SECOND_EN
            else if (!sh2_vld || sample_gt(32'(bus.data), 32'(sh2_max), SIGNED, DATA_WIDTH)) begin
                sh2_max_nx = bus.data;
                sh2_idx_nx = tag_index;
                sh2_vld_nx = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            first_q   <= 1'b0;
            sh_max    <= '0;
            sh_idx    <= '0;
            max       <= '0;
            max_index <= '0;
        end else begin
            sh_max <= sh_max_nx;
            sh_idx <= sh_idx_nx;
            if (start_ok) begin
                addr_q  <= base_addr;
                cnt_q   <= len_m1;
                first_q <= 1'b1;
            end else begin
                if (tag_valid) first_q <= 1'b0;
                if (state == SCAN) begin
                    addr_q <= addr_q + ADDR_ONE;
                    cnt_q  <= cnt_q - ADDR_ONE;
                    dcnt_q <= 3'(RD_LATENCY - 1);
                end
                if (state == DRAIN) dcnt_q <= dcnt_q - 3'd1;
            end
            // Results include the sample being compared on this same edge.
            if (commit) begin
                max       <= sh_max_nx;
                max_index <= sh_idx_nx;
            end
        end
    end

`ifdef PEAK_SCANNER_SECOND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh2_max    <= '0;
            sh2_idx    <= '0;
            sh2_vld    <= 1'b0;
            max2       <= '0;
            max2_index <= '0;
            max2_valid <= 1'b0;
        end else begin
            sh2_max <= sh2_max_nx;
            sh2_idx <= sh2_idx_nx;
            sh2_vld <= sh2_vld_nx;
            if (commit) begin
                max2       <= sh2_max_nx;
                max2_index <= sh2_idx_nx;
                max2_valid <= sh2_vld_nx;
            end
        end
    end
`endif
endmodule
